uart_rx_fifo: RTL and testbench

Receive buffer that sits directly downstream of the UART RX controller. It captures each received frame's parallel data byte on the one-cycle `DataValid` strobe and holds it in a circular FIFO until the host reads it. It reports occupancy, full and empty, and a sticky overflow flag. It decouples the bit-rate receive path from a host that may service data in bursts.

---
 rtl/uart_rx_fifo_if.sv | 45 ++++
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundle of the receive-buffer handshake signals.
//   slave  modport: the FIFO side (takes write strobe/data, read request, overflow clear;
//                   drives read data/strobe and status).
//   master modport: the RX controller / host side, mirror of slave.
// Optional feature macro: UART_RX_FIFO_AF_EN adds almost_full.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [CntW-1:0]       count;
  logic                  overflow;
  logic                  clr_overflow;
`ifdef UART_RX_FIFO_AF_EN
  logic                  almost_full;
`endif

`ifdef UART_RX_FIFO_AF_EN
  modport slave (
    input  wr_valid, wr_data, rd_en, clr_overflow,
    output rd_data, rd_valid, empty, full, count, overflow, almost_full
  );
  modport master (
    output wr_valid, wr_data, rd_en, clr_overflow,
    input  rd_data, rd_valid, empty, full, count, overflow, almost_full
  );
`else
  modport slave (
    input  wr_valid, wr_data, rd_en, clr_overflow,
    output rd_data, rd_valid, empty, full, count, overflow
  );
  modport master (
    output wr_valid, wr_data, rd_en, clr_overflow,
    input  rd_data, rd_valid, empty, full, count, overflow
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer behind the UART RX controller.
// Captures wr_data on each wr_valid strobe, returns words in order on rd_en with a
// one-cycle registered read, reports count/empty/full and a sticky overflow flag.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - uart_rx_fifo_if.slave (wr_valid, wr_data, rd_en, clr_overflow in;
//          rd_data, rd_valid, empty, full, count, overflow [, almost_full] out)
// Optional feature macro: UART_RX_FIFO_AF_EN enables almost_full = (count >= AF_LEVEL).
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_LEVEL   = 6
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;

  logic empty, full;
  logic wr_accept, rd_accept, wr_drop;

  // Status comes from the registered count only.
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  // A simultaneous read frees a slot, so a write is still taken while full.
  assign wr_accept = bus.wr_valid && (!full || bus.rd_en);
  assign rd_accept = bus.rd_en && !empty;
  assign wr_drop   = bus.wr_valid && full && !bus.rd_en;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;

    if (wr_accept) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (rd_accept) begin
      rptr_d     = rptr_q + PtrW'(1);
      rd_data_d  = mem_q[rptr_q];
      rd_valid_d = 1'b1;
    end

    if (wr_accept && !rd_accept) begin
      count_d = count_q + CntW'(1);
    end else if (rd_accept && !wr_accept) begin
      count_d = count_q - CntW'(1);
    end

    // Set has priority over clear.
    if (wr_drop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset. When full with a concurrent read and write,
  // wptr == rptr; the read above samples the old word before this update lands.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

`ifdef UART_RX_FIFO_AF_EN
  assign bus.almost_full = (count_q >= CntW'(AF_LEVEL));
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_valid     = 1'b0;
    bus.wr_data      = '0;
    bus.rd_en        = 1'b0;
    bus.clr_overflow = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".count"},    32'(bus.count),    32'd0);
    chk({tag, ".empty"},    32'(bus.empty),    32'd1);
    chk({tag, ".full"},     32'(bus.full),     32'd0);
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, ".rd_data"},  32'(bus.rd_data),  32'd0);
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
`ifdef UART_RX_FIFO_AF_EN
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'd0);
`endif
  endtask

  initial begin
    int max_cnt;
    total = 0;
    bad   = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state("reset");

    // Two words in, two out.
    bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
    tick();
    chk("t1.count1", 32'(bus.count), 32'd1);
    chk("t1.empty0", 32'(bus.empty), 32'd0);
    bus.wr_data = 8'h3C;
    tick();
    chk("t1.count2", 32'(bus.count), 32'd2);
    bus.wr_valid = 1'b0; bus.rd_en = 1'b1;
    tick();
    chk("t1.rd0_data",  32'(bus.rd_data),  32'hA5);
    chk("t1.rd0_valid", 32'(bus.rd_valid), 32'd1);
    chk("t1.rd0_count", 32'(bus.count),    32'd1);
    tick();
    chk("t1.rd1_data",  32'(bus.rd_data),  32'h3C);
    chk("t1.rd1_valid", 32'(bus.rd_valid), 32'd1);
    chk("t1.rd1_count", 32'(bus.count),    32'd0);
    chk("t1.empty1",    32'(bus.empty),    32'd1);
    bus.rd_en = 1'b0;
    tick();
    chk("t1.valid_drop", 32'(bus.rd_valid), 32'd0);
    chk("t1.data_hold",  32'(bus.rd_data),  32'h3C);

    // Fill, overflow, drain, clear.
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 8'(i);
      tick();
    end
    chk("t2.full",      32'(bus.full),     32'd1);
    chk("t2.count8",    32'(bus.count),    32'd8);
    chk("t2.no_ovf",    32'(bus.overflow), 32'd0);
    bus.wr_data = 8'hFF;
    tick();
    bus.wr_valid = 1'b0;
    chk("t2.ovf",       32'(bus.overflow), 32'd1);
    chk("t2.ovf_count", 32'(bus.count),    32'd8);
    chk("t2.ovf_full",  32'(bus.full),     32'd1);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2.rd%0d_data", i), 32'(bus.rd_data), 32'(i));
      chk($sformatf("t2.rd%0d_valid", i), 32'(bus.rd_valid), 32'd1);
    end
    bus.rd_en = 1'b0;
    tick();
    chk("t2.empty",       32'(bus.empty),    32'd1);
    chk("t2.no_ff_valid", 32'(bus.rd_valid), 32'd0);
    chk("t2.ovf_sticky",  32'(bus.overflow), 32'd1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    chk("t2.ovf_clr", 32'(bus.overflow), 32'd0);

    // Refill; overflow set beats clear in the same cycle.
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 8'(8'h10 + i);
      tick();
    end
    bus.wr_data = 8'h99; bus.clr_overflow = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.clr_overflow = 1'b0;
    chk("t3.set_wins",  32'(bus.overflow), 32'd1);
    chk("t3.count8",    32'(bus.count),    32'd8);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    chk("t3.ovf_clr", 32'(bus.overflow), 32'd0);
    // Full with simultaneous write and read.
    bus.wr_valid = 1'b1; bus.wr_data = 8'h55; bus.rd_en = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    chk("t3.rw_data",  32'(bus.rd_data),  32'h10);
    chk("t3.rw_valid", 32'(bus.rd_valid), 32'd1);
    chk("t3.rw_count", 32'(bus.count),    32'd8);
    chk("t3.rw_ovf",   32'(bus.overflow), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("t3.rd%0d", i), 32'(bus.rd_data), 32'(8'h10 + i));
    end
    tick();
    chk("t3.rd_55",  32'(bus.rd_data), 32'h55);
    chk("t3.empty",  32'(bus.empty),   32'd1);

    // Empty: read alone ignored, then write+read takes only the write.
    tick();
    chk("t4.ign_valid", 32'(bus.rd_valid), 32'd0);
    chk("t4.ign_data",  32'(bus.rd_data),  32'h55);
    chk("t4.ign_count", 32'(bus.count),    32'd0);
    bus.wr_valid = 1'b1; bus.wr_data = 8'h11;
    tick();
    bus.wr_valid = 1'b0;
    chk("t4.wr_count", 32'(bus.count),    32'd1);
    chk("t4.wr_valid", 32'(bus.rd_valid), 32'd0);
    chk("t4.wr_data",  32'(bus.rd_data),  32'h55);
    tick();
    bus.rd_en = 1'b0;
    chk("t4.rd_data",  32'(bus.rd_data), 32'h11);
    chk("t4.rd_count", 32'(bus.count),   32'd0);

    // Pointer wrap with 20 write/read pairs.
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 8'(i); bus.rd_en = 1'b0;
      tick();
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      bus.wr_valid = 1'b0; bus.rd_en = 1'b1;
      tick();
      chk($sformatf("t5.rd%0d", i), 32'(bus.rd_data), 32'(i));
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end
    bus.rd_en = 1'b0;
    chk("t5.max_count", 32'(max_cnt), 32'd1);

`ifdef UART_RX_FIFO_AF_EN
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 8'(8'h40 + i);
      tick();
    end
    chk("t6.af_at5", 32'(bus.almost_full), 32'd0);
    bus.wr_data = 8'h45;
    tick();
    bus.wr_valid = 1'b0;
    chk("t6.af_at6", 32'(bus.almost_full), 32'd1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("t6.af_rd",  32'(bus.almost_full), 32'd0);
    chk("t6.af_dat", 32'(bus.rd_data),     32'h40);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.rd_en = 1'b0;
    tick();
`endif

    // Reset mid-operation with a full FIFO and overflow pending.
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 8'(8'hC0 + i);
      tick();
    end
    bus.wr_data = 8'hEE;
    tick();
    chk("t7.pre_ovf", 32'(bus.overflow), 32'd1);
    bus.rd_en = 1'b1;
    tick();
    chk("t7.pre_data", 32'(bus.rd_data), 32'hC0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk_reset_state("t7.rst");
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("t7.post_valid", 32'(bus.rd_valid), 32'd0);
    chk("t7.post_count", 32'(bus.count),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
